// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, defaults and FSM state type for the timer sequencer
package timer_pkg;
  localparam int VAL_W = 5;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PRESCALE = 4;
  typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_e;
endpackage

// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: interval stream input plus timer load/tick/feedback bundle
interface timer_sequencer_if #(parameter int DEPTH = 4) ();
  import timer_pkg::*;
  logic [VAL_W-1:0] in_value;
  logic in_valid;
  logic in_ready;
  logic [VAL_W-1:0] count;
  logic [VAL_W-1:0] value;
  logic valid;
  logic enable;
  logic done;
  logic busy;
  logic [$clog2(DEPTH+1)-1:0] level;
  modport slave (
    input in_value, in_valid, count,
    output in_ready, value, valid, enable, done, busy, level
  );
  modport master (
    output in_value, in_valid, count,
    input in_ready, value, valid, enable, done, busy, level
  );
endinterface

// File: rtl/timer_seq_fifo.sv
// timer_seq_fifo: power-of-two synchronous FIFO with occupancy counter
module timer_seq_fifo import timer_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic [VAL_W-1:0] din_i,
  input  logic pop_i,
  output logic [VAL_W-1:0] head_o,
  output logic full_o,
  output logic empty_o,
  output logic [LW-1:0] level_o
);
  logic [VAL_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic push, pop;
  assign push = push_i && !full_o;
  assign pop = pop_i && !empty_o;
  assign full_o = cnt_q == LW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din_i;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: queues intervals and feeds them to the countdown timer with a prescaled tick
module timer_sequencer import timer_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input logic clk,
  input logic reset,
  timer_sequencer_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE-1);
  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic full, empty;
  logic [VAL_W-1:0] head;
  logic [$clog2(DEPTH+1)-1:0] level;
  timer_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(bus.in_valid),
    .din_i(bus.in_value),
    .pop_i(state_q == LOAD),
    .head_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(level)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      pre_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
    end
  // count feedback only steers the RUN exit; empty is the pre-pop occupancy
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    unique case (state_q)
      IDLE: state_d = empty ? IDLE : LOAD;
      LOAD: state_d = ARM;
      ARM: begin
        state_d = RUN;
        pre_d = '0;
      end
      RUN: begin
        state_d = bus.count != '0 ? RUN : (empty ? IDLE : LOAD);
        pre_d = pre_q == PMAX ? '0 : pre_q + 1'b1;
      end
    endcase
  end
  assign bus.valid = state_q == LOAD;
  assign bus.value = bus.valid ? head : '0;
  assign bus.enable = state_q == RUN && pre_q == PMAX;
  assign bus.done = state_q == RUN && bus.count == '0;
  assign bus.busy = state_q != IDLE;
  assign bus.in_ready = !full;
  assign bus.level = level;
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed plus random stimulus against a job-timeline reference model
module tb_timer_sequencer;
  localparam int DEPTH = 4;
  localparam int P = 4;
  logic clk = 0;
  logic reset;
  logic [4:0] tcount;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit checking = 0;
  int q[$];
  bit active = 0;
  int job_start = 0, job_v = 0;
  bit acc_last;
  int en_cnt, done_cnt, valid_cnt;
  bit saw_full;
  int stim[$];

  timer_sequencer_if #(.DEPTH(DEPTH)) bus ();
  timer_sequencer #(.DEPTH(DEPTH), .PRESCALE(P)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (reset) tcount <= '0;
    else if (bus.valid) tcount <= bus.value;
    else if (bus.enable && tcount != 0) tcount <= tcount - 1'b1;
  assign bus.count = tcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the job timeline: LOAD at job_start, RUN from job_start+2 for V*P+1 cycles
  task automatic tick();
    bit vexp, run, eexp, dexp, start;
    int rel;
    vexp = active && cyc == job_start;
    rel = cyc - (job_start + 2);
    run = active && rel >= 0 && rel <= job_v * P;
    eexp = run && (rel % P) == P - 1;
    dexp = run && rel == job_v * P;
    if (checking) begin
      chk("in_ready", bus.in_ready, q.size() < DEPTH);
      chk("level", bus.level, q.size());
      chk("valid", bus.valid, vexp);
      chk("value", bus.value, vexp ? job_v : 0);
      chk("enable", bus.enable, eexp);
      chk("done", bus.done, dexp);
      chk("busy", bus.busy, active);
      en_cnt += int'(bus.enable);
      done_cnt += int'(bus.done);
      valid_cnt += int'(bus.valid);
      if (!bus.in_ready) saw_full = 1;
    end
    acc_last = !reset && bus.in_valid && q.size() < DEPTH;
    if (reset) begin
      q.delete();
      active = 0;
    end else begin
      start = q.size() > 0 && (!active || dexp);
      if (dexp && !start) active = 0;
      if (vexp) void'(q.pop_front());
      if (acc_last) q.push_back(int'(bus.in_value));
      if (start) begin
        active = 1;
        job_start = cyc + 1;
        job_v = q[0];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_stim();
    while (stim.size() > 0) begin
      int n = 0;
      bus.in_valid = 1;
      bus.in_value = 5'(stim[0]);
      do begin
        tick();
        n++;
      end while (!acc_last && n < 300);
      if (!acc_last) chk("push_timeout", 0, 1);
      void'(stim.pop_front());
    end
    bus.in_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && (active || q.size() > 0); i++) tick();
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic clr_counts();
    en_cnt = 0;
    done_cnt = 0;
    valid_cnt = 0;
    saw_full = 0;
  endtask

  initial begin
    reset = 1;
    bus.in_valid = 0;
    bus.in_value = 0;
    tick();
    tick();
    reset = 0;
    checking = 1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_valid", bus.valid, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_level", bus.level, 0);
    tick();

    clr_counts();
    stim = '{3};
    push_stim();
    wait_idle(40);
    chk("single_enables", en_cnt, 3);
    chk("single_dones", done_cnt, 1);

    clr_counts();
    stim = '{2, 1};
    push_stim();
    wait_idle(60);
    chk("b2b_dones", done_cnt, 2);
    chk("b2b_valids", valid_cnt, 2);

    clr_counts();
    stim = '{2};
    push_stim();
    repeat (4) tick();
    stim = '{1, 2, 3, 1, 2};
    push_stim();
    wait_idle(200);
    chk("full_seen", saw_full, 1);
    chk("full_valids", valid_cnt, 6);

    clr_counts();
    stim = '{0};
    push_stim();
    wait_idle(20);
    chk("zero_enables", en_cnt, 0);
    chk("zero_dones", done_cnt, 1);

    clr_counts();
    stim = '{3, 1, 2};
    push_stim();
    repeat (5) tick();
    chk("mid_busy", bus.busy, 1);
    reset = 1;
    tick();
    reset = 0;
    clr_counts();
    repeat (8) tick();
    chk("post_rst_valids", valid_cnt, 0);
    chk("post_rst_level", bus.level, 0);

    for (int i = 0; i < 500; i++) begin
      reset = ($urandom % 150) == 0;
      bus.in_valid = ($urandom % 3) == 0;
      bus.in_value = 5'($urandom % 4);
      tick();
    end
    reset = 0;
    bus.in_valid = 0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
